// File: rtl/button_debouncer_if.sv
// Button conditioning bundle: raw pins in, debounced level and edge strobes out.
interface button_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  modport master (output btn_raw, input btn_level, btn_press, btn_release);
  modport slave  (input btn_raw, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/button_debouncer.sv
// Per-channel 2-flop synchronizer followed by an integrating debounce counter;
// emits a clean active-high level and single-cycle press/release strobes.
module button_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                reset,
  button_debouncer_if.slave   bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {STABLE = 1'b0, COUNTING = 1'b1} state_t;

  logic [WIDTH-1:0] pressed_raw;
  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  state_t [WIDTH-1:0]            state_q, state_d;
  logic   [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic   [WIDTH-1:0]            lvl_q, lvl_d;
  logic   [WIDTH-1:0]            press_q, press_d;
  logic   [WIDTH-1:0]            release_q, release_d;

  assign pressed_raw = (ACTIVE_LOW != 0) ? ~bus.btn_raw : bus.btn_raw;

  // Stage p0/p1: metastability synchronizer, nothing between the two flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pressed_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce decision: a new level must be seen DEBOUNCE_CYCLES samples in a row
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lvl_d     = lvl_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (state_q[i])
        STABLE: begin
          if (sync_p1[i] != lvl_q[i]) begin
            cnt_d[i]   = CNT_ONE;
            state_d[i] = COUNTING;
          end
        end
        COUNTING: begin
          if (sync_p1[i] == lvl_q[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else if (cnt_q[i] == CNT_MAX) begin
            lvl_d[i]     = sync_p1[i];
            press_d[i]   = sync_p1[i];
            release_d[i] = ~sync_p1[i];
            cnt_d[i]     = '0;
            state_d[i]   = STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = STABLE;
        end
      endcase
    end
  end

  // Stage p2: accepted level and strobes, all registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      lvl_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign bus.btn_level   = lvl_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed and randomized bench for button_debouncer against a run-length reference model.
module tb_button_debouncer;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_debouncer_if #(.WIDTH(WIDTH)) bus ();

  button_debouncer #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: two-sample delay of the pressed view, and for each channel the
  // length of the current run of samples that disagree with the accepted level.
  logic [WIDTH-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
  int               m_run [WIDTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [WIDTH-1:0] p;
    p = ~bus.btn_raw;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i]   = m_s2[i];
          m_press[i] = m_s2[i];
          m_rel[i]   = ~m_s2[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = p;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    chk("model_level",   32'(bus.btn_level),   32'(m_lvl));
    chk("model_press",   32'(bus.btn_press),   32'(m_press));
    chk("model_release", 32'(bus.btn_release), 32'(m_rel));
  endtask

  // Returns the number of edges until the selected strobe fires, or -1 on timeout.
  task automatic wait_strobe(input logic [WIDTH-1:0] mask, input bit want_press, output int e);
    e = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (((want_press ? bus.btn_press : bus.btn_release) & mask) != '0) begin
        e = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int cnt;
    int hold;

    // Reset with all buttons physically released
    reset = 1'b1;
    bus.btn_raw = 4'hF;
    model_clear();
    repeat (3) tick();
    chk("reset_level",   32'(bus.btn_level),   32'h0);
    chk("reset_press",   32'(bus.btn_press),   32'h0);
    chk("reset_release", 32'(bus.btn_release), 32'h0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt += int'(|(bus.btn_press | bus.btn_release));
    end
    chk("idle_no_strobe", 32'(cnt), 32'd0);

    // Clean press and release of bit 0
    bus.btn_raw = 4'hE;
    wait_strobe(4'h1, 1'b1, e);
    chk("press_latency", 32'(e), 32'd6);
    chk("press_level",   32'(bus.btn_level), 32'h1);
    chk("press_strobe",  32'(bus.btn_press), 32'h1);
    tick();
    chk("press_one_cycle", 32'(bus.btn_press), 32'h0);
    repeat (3) tick();
    bus.btn_raw = 4'hF;
    wait_strobe(4'h1, 1'b0, e);
    chk("release_latency", 32'(e), 32'd6);
    chk("release_level",   32'(bus.btn_level),   32'h0);
    chk("release_strobe",  32'(bus.btn_release), 32'h1);
    tick();
    chk("release_one_cycle", 32'(bus.btn_release), 32'h0);
    repeat (3) tick();

    // Bouncy press on bit 1
    cnt = 0;
    for (int k = 0; k < 27; k++) begin
      bus.btn_raw = (k == 3) ? 4'hF : 4'hD;
      tick();
      cnt += int'(bus.btn_press[1]);
    end
    chk("bounce_press_count", 32'(cnt), 32'd1);
    chk("bounce_level", 32'(bus.btn_level), 32'h2);
    bus.btn_raw = 4'hF;
    repeat (12) tick();
    chk("bounce_released", 32'(bus.btn_level), 32'h0);

    // Short glitch on bit 2 must be ignored
    cnt = 0;
    bus.btn_raw = 4'hB;
    for (int k = 0; k < 18; k++) begin
      if (k == 3) bus.btn_raw = 4'hF;
      tick();
      cnt += int'(bus.btn_press[2] | bus.btn_release[2] | bus.btn_level[2]);
    end
    chk("glitch_no_effect", 32'(cnt), 32'd0);

    // Simultaneous press of bits 0 and 3
    bus.btn_raw = 4'h6;
    wait_strobe(4'h9, 1'b1, e);
    chk("simul_latency", 32'(e), 32'd6);
    chk("simul_press", 32'(bus.btn_press), 32'h9);
    chk("simul_level", 32'(bus.btn_level), 32'h9);
    bus.btn_raw = 4'hF;
    repeat (12) tick();
    chk("simul_released", 32'(bus.btn_level), 32'h0);

    // Randomized hold lengths straddling the debounce window
    for (int seg = 0; seg < 80; seg++) begin
      bus.btn_raw = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 8);
      repeat (hold) tick();
    end
    bus.btn_raw = 4'hF;
    repeat (12) tick();
    chk("random_settled", 32'(bus.btn_level), 32'h0);

    // Reset arriving mid-count with bit 0 held
    bus.btn_raw = 4'hE;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    model_clear();
    chk("midreset_level",   32'(bus.btn_level),   32'h0);
    chk("midreset_press",   32'(bus.btn_press),   32'h0);
    chk("midreset_release", 32'(bus.btn_release), 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    wait_strobe(4'h1, 1'b1, e);
    chk("post_reset_latency", 32'(e), 32'd6);
    chk("post_reset_level",   32'(bus.btn_level), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
